// File: rtl/itlb_ptw_if.sv
// Bundle of every non-clock/reset signal between the Sv32 ITLB page-table
// walker and its environment (ITLB miss path, fetch-side memory read port).
// The "slave" modport is the walker's view; "master" is the environment's view.
interface itlb_ptw_if #(
  parameter int VADDR_WD = 32,
  parameter int PADDR_WD = 34,
  parameter int ASID_WD  = 9,
  parameter int PPN_WD   = 22
);
  // control / configuration
  logic                flush_i;
  logic [PPN_WD-1:0]   satp_ppn_i;

  // ITLB miss request
  logic                req_valid_i;
  logic                req_ready_o;
  logic [VADDR_WD-1:0] req_vaddr_i;
  logic [ASID_WD-1:0]  req_asid_i;

  // PTE read port
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic [PADDR_WD-1:0] mem_req_addr_o;
  logic                mem_rsp_valid_i;
  logic [31:0]         mem_rsp_data_i;

  // refill / fault result
  logic                refill_valid_o;
  logic [19:0]         refill_vpn_o;
  logic [ASID_WD-1:0]  refill_asid_o;
  logic [31:0]         refill_pte_o;
  logic                refill_super_o;
  logic                page_fault_o;

  // Environment side: drives requests, memory readiness and responses.
  modport master (
    output flush_i, satp_ppn_i,
    output req_valid_i, req_vaddr_i, req_asid_i,
    input  req_ready_o,
    input  mem_req_valid_o, mem_req_addr_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  refill_valid_o, refill_vpn_o, refill_asid_o, refill_pte_o,
    input  refill_super_o, page_fault_o
  );

  // Walker side.
  modport slave (
    input  flush_i, satp_ppn_i,
    input  req_valid_i, req_vaddr_i, req_asid_i,
    output req_ready_o,
    output mem_req_valid_o, mem_req_addr_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output refill_valid_o, refill_vpn_o, refill_asid_o, refill_pte_o,
    output refill_super_o, page_fault_o
  );
endinterface

// File: rtl/itlb_ptw.sv
// Sv32 page-table walker for ITLB misses. One walk in flight: up to two PTE
// reads, Sv32 permission/alignment checks for instruction fetch, then either a
// one-cycle refill pulse or a one-cycle instruction page-fault pulse.
// A flush aborts the walk; an already-accepted PTE read is drained silently.
module itlb_ptw #(
  parameter int VADDR_WD = 32,
  parameter int PADDR_WD = 34,
  parameter int ASID_WD  = 9,
  parameter int PPN_WD   = 22
) (
  input  logic          clk_i,
  input  logic          rst_i,
  itlb_ptw_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_DONE    = 3'd5,
    S_FAULT   = 3'd6,
    S_DRAIN   = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Latched request context. The root PPN is folded into the level-1 address
  // at accept time, so it needs no register of its own.
  logic [19:0]         r_vpn;
  logic [ASID_WD-1:0]  r_asid;
  logic [PADDR_WD-1:0] r_mem_addr;

  logic [19:0]         r_refill_vpn;
  logic [ASID_WD-1:0]  r_refill_asid;
  logic [31:0]         r_refill_pte;
  logic                r_refill_super;

  // PTE address computation: {PPN,12'b0} + {vpn_i,2'b00}
  logic [PADDR_WD-1:0] w_l1_addr;
  logic [PADDR_WD-1:0] w_l0_addr;

  assign w_l1_addr = {bus.satp_ppn_i, 12'b0}
                   + {{(PADDR_WD-12){1'b0}}, bus.req_vaddr_i[VADDR_WD-1 -: 10], 2'b00};
  assign w_l0_addr = {bus.mem_rsp_data_i[31:10], 12'b0}
                   + {{(PADDR_WD-12){1'b0}}, r_vpn[9:0], 2'b00};

  // PTE decode of the incoming response
  logic w_pte_v, w_pte_r, w_pte_w, w_pte_x, w_pte_a;
  logic w_pte_bad, w_pte_leaf, w_l1_fault, w_l0_fault;

  assign w_pte_v    = bus.mem_rsp_data_i[0];
  assign w_pte_r    = bus.mem_rsp_data_i[1];
  assign w_pte_w    = bus.mem_rsp_data_i[2];
  assign w_pte_x    = bus.mem_rsp_data_i[3];
  assign w_pte_a    = bus.mem_rsp_data_i[6];
  // Invalid, or the reserved W-without-R encoding
  assign w_pte_bad  = !w_pte_v || (!w_pte_r && w_pte_w);
  assign w_pte_leaf = w_pte_r || w_pte_x;
  // Megapage leaf must be executable, accessed and 4 MiB aligned (PPN0 == 0)
  assign w_l1_fault = w_pte_bad ||
                      (w_pte_leaf && (!w_pte_x || !w_pte_a ||
                                      (bus.mem_rsp_data_i[19:10] != 10'd0)));
  // Level 0 must hold an executable, accessed leaf; a pointer here is a fault
  assign w_l0_fault = w_pte_bad || !w_pte_leaf || !w_pte_x || !w_pte_a;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: walk sequencing, flush abort and drain of accepted reads
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid_i) w_state_next = S_L1_REQ;
      end
      S_L1_REQ: begin
        if (bus.flush_i)              w_state_next = bus.mem_req_ready_i ? S_DRAIN : S_IDLE;
        else if (bus.mem_req_ready_i) w_state_next = S_L1_WAIT;
      end
      S_L1_WAIT: begin
        if (bus.flush_i) begin
          w_state_next = bus.mem_rsp_valid_i ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rsp_valid_i) begin
          if (w_l1_fault)      w_state_next = S_FAULT;
          else if (w_pte_leaf) w_state_next = S_DONE;
          else                 w_state_next = S_L0_REQ;
        end
      end
      S_L0_REQ: begin
        if (bus.flush_i)              w_state_next = bus.mem_req_ready_i ? S_DRAIN : S_IDLE;
        else if (bus.mem_req_ready_i) w_state_next = S_L0_WAIT;
      end
      S_L0_WAIT: begin
        if (bus.flush_i) begin
          w_state_next = bus.mem_rsp_valid_i ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rsp_valid_i) begin
          w_state_next = w_l0_fault ? S_FAULT : S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_FAULT: w_state_next = S_IDLE;
      S_DRAIN: begin
        if (bus.mem_rsp_valid_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: handshakes and pulses decoded straight from the state
  always_comb begin
    bus.req_ready_o     = 1'b0;
    bus.mem_req_valid_o = 1'b0;
    bus.refill_valid_o  = 1'b0;
    bus.page_fault_o    = 1'b0;
    case (r_state)
      S_IDLE:   bus.req_ready_o     = 1'b1;
      S_L1_REQ: bus.mem_req_valid_o = 1'b1;
      S_L0_REQ: bus.mem_req_valid_o = 1'b1;
      S_DONE:   bus.refill_valid_o  = 1'b1;
      S_FAULT:  bus.page_fault_o    = 1'b1;
      default:  ;
    endcase
  end

  // Request context and PTE address; address only changes between requests,
  // so it stays stable while the memory port back-pressures
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vpn      <= '0;
      r_asid     <= '0;
      r_mem_addr <= '0;
    end else if (r_state == S_IDLE && bus.req_valid_i) begin
      r_vpn      <= bus.req_vaddr_i[VADDR_WD-1 -: 20];
      r_asid     <= bus.req_asid_i;
      r_mem_addr <= w_l1_addr;
    end else if (r_state == S_L1_WAIT && w_state_next == S_L0_REQ) begin
      r_mem_addr <= w_l0_addr;
    end
  end

  // Refill fields: captured with the leaf PTE, held until the next refill
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_refill_vpn   <= '0;
      r_refill_asid  <= '0;
      r_refill_pte   <= '0;
      r_refill_super <= 1'b0;
    end else if (w_state_next == S_DONE && r_state != S_DONE) begin
      r_refill_vpn   <= r_vpn;
      r_refill_asid  <= r_asid;
      r_refill_pte   <= bus.mem_rsp_data_i;
      r_refill_super <= (r_state == S_L1_WAIT);
    end
  end

  assign bus.mem_req_addr_o = r_mem_addr;
  assign bus.refill_vpn_o   = r_refill_vpn;
  assign bus.refill_asid_o  = r_refill_asid;
  assign bus.refill_pte_o   = r_refill_pte;
  assign bus.refill_super_o = r_refill_super;

endmodule

// File: tb/tb_itlb_ptw.sv
// Directed self-checking bench for the Sv32 ITLB page-table walker.
module tb_itlb_ptw;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  itlb_ptw_if #(.VADDR_WD(32), .PADDR_WD(34), .ASID_WD(9), .PPN_WD(22)) bus ();

  itlb_ptw #(.VADDR_WD(32), .PADDR_WD(34), .ASID_WD(9), .PPN_WD(22)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // observations collected by run_walk
  int          o_nmem, o_refills, o_faults, o_lat, o_ready_busy, o_unstable, o_extra;
  logic [33:0] o_addr0, o_addr1;
  logic [19:0] o_vpn;
  logic [8:0]  o_asid;
  logic [31:0] o_pte;
  logic        o_super;

  localparam logic [31:0] VA = 32'h0040_1234;

  // Drives one walk with a 1-cycle-response memory model; `stall` cycles of
  // mem_req_ready_i=0 precede each accepted PTE read.
  task automatic run_walk(input logic [31:0] va, input logic [8:0] asid,
                          input logic [21:0] satp, input logic [31:0] pte1,
                          input logic [31:0] pte0, input int stall);
    int          stall_cnt;
    bit          pend;
    logic [33:0] held;
    stall_cnt = 0; pend = 0; held = '0;
    o_nmem = 0; o_refills = 0; o_faults = 0; o_lat = -1;
    o_ready_busy = 0; o_unstable = 0; o_extra = 0;
    o_addr0 = '0; o_addr1 = '0;
    @(negedge clk);
    bus.satp_ppn_i  = satp;
    bus.req_vaddr_i = va;
    bus.req_asid_i  = asid;
    bus.req_valid_i = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.req_valid_i     = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_req_ready_i = 1'b0;
      if (o_lat > 0) begin
        if (bus.refill_valid_o || bus.page_fault_o) o_extra++;
        break;
      end
      if (bus.refill_valid_o) begin
        o_refills++; o_lat = cyc;
        o_vpn = bus.refill_vpn_o; o_asid = bus.refill_asid_o;
        o_pte = bus.refill_pte_o; o_super = bus.refill_super_o;
      end
      if (bus.page_fault_o) begin
        o_faults++; o_lat = cyc;
      end
      if (bus.req_ready_o) o_ready_busy++;
      if (pend) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = (o_nmem == 1) ? pte1 : pte0;
        pend = 0;
      end
      if (bus.mem_req_valid_o) begin
        if (stall_cnt > 0 && bus.mem_req_addr_o !== held) o_unstable++;
        held = bus.mem_req_addr_o;
        if (stall_cnt < stall) begin
          stall_cnt++;
        end else begin
          bus.mem_req_ready_i = 1'b1;
          if (o_nmem == 0) o_addr0 = bus.mem_req_addr_o;
          else             o_addr1 = bus.mem_req_addr_o;
          o_nmem++;
          pend = 1;
          stall_cnt = 0;
        end
      end else if (stall_cnt > 0) begin
        o_unstable++;
      end
    end
    $display("walk va=%h asid=%0d pte1=%h pte0=%h stall=%0d -> reads=%0d refill=%0d fault=%0d lat=%0d",
             va, asid, pte1, pte0, stall, o_nmem, o_refills, o_faults, o_lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.satp_ppn_i = '0; bus.req_valid_i = 1'b0;
    bus.req_vaddr_i = '0; bus.req_asid_i = '0; bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_data_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready_o); end
    n_checks++; if (bus.mem_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_mem_valid got %b want 0", bus.mem_req_valid_o); end
    n_checks++; if (bus.mem_req_addr_o !== 34'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_req_addr_o); end
    n_checks++; if (bus.refill_valid_o !== 1'b0 || bus.page_fault_o !== 1'b0) begin n_errors++; $display("FAIL reset_pulses got refill=%b fault=%b want 0/0", bus.refill_valid_o, bus.page_fault_o); end
    n_checks++; if ({bus.refill_vpn_o, bus.refill_asid_o, bus.refill_pte_o, bus.refill_super_o} !== '0) begin n_errors++; $display("FAIL reset_refill_fields got vpn=%h asid=%h pte=%h super=%b want 0", bus.refill_vpn_o, bus.refill_asid_o, bus.refill_pte_o, bus.refill_super_o); end
    $display("reset done");
  endtask

  task automatic test_walk_4k();
    run_walk(VA, 9'd5, 22'h00080, 32'h0002_0401, 32'h0004_8C4B, 0);
    n_checks++; if (o_addr0 !== 34'h0_0008_0004) begin n_errors++; $display("FAIL 4k_l1_addr got %h want 000080004", o_addr0); end
    n_checks++; if (o_addr1 !== 34'h0_0008_1004) begin n_errors++; $display("FAIL 4k_l0_addr got %h want 000081004", o_addr1); end
    n_checks++; if (o_nmem !== 2) begin n_errors++; $display("FAIL 4k_reads got %0d want 2", o_nmem); end
    n_checks++; if (o_refills !== 1 || o_faults !== 0) begin n_errors++; $display("FAIL 4k_result got refill=%0d fault=%0d want 1/0", o_refills, o_faults); end
    n_checks++; if (o_lat !== 5) begin n_errors++; $display("FAIL 4k_latency got %0d want 5", o_lat); end
    n_checks++; if (o_vpn !== 20'h00401) begin n_errors++; $display("FAIL 4k_vpn got %h want 00401", o_vpn); end
    n_checks++; if (o_pte !== 32'h0004_8C4B) begin n_errors++; $display("FAIL 4k_pte got %h want 00048c4b", o_pte); end
    n_checks++; if (o_super !== 1'b0) begin n_errors++; $display("FAIL 4k_super got %b want 0", o_super); end
    n_checks++; if (o_asid !== 9'd5) begin n_errors++; $display("FAIL 4k_asid got %0d want 5", o_asid); end
    n_checks++; if (o_ready_busy !== 0) begin n_errors++; $display("FAIL 4k_ready_busy got %0d cycles want 0", o_ready_busy); end
    n_checks++; if (o_extra !== 0) begin n_errors++; $display("FAIL 4k_pulse_width got %0d extra want 0", o_extra); end
    n_checks++; if (bus.refill_pte_o !== 32'h0004_8C4B || bus.req_ready_o !== 1'b1) begin n_errors++; $display("FAIL 4k_hold got pte=%h ready=%b want 00048c4b/1", bus.refill_pte_o, bus.req_ready_o); end
  endtask

  task automatic test_megapage();
    run_walk(VA, 9'd5, 22'h00080, 32'h0010_004B, 32'h0, 0);
    n_checks++; if (o_nmem !== 1 || o_addr0 !== 34'h0_0008_0004) begin n_errors++; $display("FAIL mega_read got n=%0d addr=%h want 1/000080004", o_nmem, o_addr0); end
    n_checks++; if (o_refills !== 1 || o_faults !== 0) begin n_errors++; $display("FAIL mega_result got refill=%0d fault=%0d want 1/0", o_refills, o_faults); end
    n_checks++; if (o_lat !== 3) begin n_errors++; $display("FAIL mega_latency got %0d want 3", o_lat); end
    n_checks++; if (o_super !== 1'b1) begin n_errors++; $display("FAIL mega_super got %b want 1", o_super); end
    n_checks++; if (o_pte !== 32'h0010_004B) begin n_errors++; $display("FAIL mega_pte got %h want 0010004b", o_pte); end
    n_checks++; if (o_extra !== 0) begin n_errors++; $display("FAIL mega_pulse_width got %0d extra want 0", o_extra); end
  endtask

  task automatic test_faults();
    logic [31:0] t_pte1 [4];
    logic [31:0] t_pte0 [4];
    int          t_reads[4];
    int          t_lat  [4];
    t_pte1 = '{32'h0010_044B, 32'h0002_0401, 32'h0002_0401, 32'h0002_0401};
    t_pte0 = '{32'h0,         32'h0004_8C4A, 32'h0004_8C43, 32'h0002_0401};
    t_reads = '{1, 2, 2, 2};
    t_lat   = '{3, 5, 5, 5};
    for (int i = 0; i < 4; i++) begin
      run_walk(VA, 9'd6, 22'h00080, t_pte1[i], t_pte0[i], 0);
      n_checks++; if (o_faults !== 1 || o_refills !== 0) begin n_errors++; $display("FAIL fault%0d_result got fault=%0d refill=%0d want 1/0", i, o_faults, o_refills); end
      n_checks++; if (o_nmem !== t_reads[i] || o_lat !== t_lat[i]) begin n_errors++; $display("FAIL fault%0d_timing got reads=%0d lat=%0d want %0d/%0d", i, o_nmem, o_lat, t_reads[i], t_lat[i]); end
      n_checks++; if (o_extra !== 0) begin n_errors++; $display("FAIL fault%0d_pulse_width got %0d extra want 0", i, o_extra); end
      // last refill (megapage) must be untouched by faulting walks
      n_checks++; if (bus.refill_pte_o !== 32'h0010_004B || bus.refill_asid_o !== 9'd5) begin n_errors++; $display("FAIL fault%0d_hold got pte=%h asid=%0d want 0010004b/5", i, bus.refill_pte_o, bus.refill_asid_o); end
    end
  endtask

  task automatic test_backpressure();
    run_walk(VA, 9'd5, 22'h00080, 32'h0002_0401, 32'h0004_8C4B, 4);
    n_checks++; if (o_unstable !== 0) begin n_errors++; $display("FAIL bp_stable got %0d changes want 0", o_unstable); end
    n_checks++; if (o_ready_busy !== 0) begin n_errors++; $display("FAIL bp_ready_busy got %0d want 0", o_ready_busy); end
    n_checks++; if (o_addr0 !== 34'h0_0008_0004 || o_addr1 !== 34'h0_0008_1004) begin n_errors++; $display("FAIL bp_addrs got %h %h want 000080004 000081004", o_addr0, o_addr1); end
    n_checks++; if (o_refills !== 1 || o_pte !== 32'h0004_8C4B || o_super !== 1'b0) begin n_errors++; $display("FAIL bp_refill got n=%0d pte=%h super=%b want 1/00048c4b/0", o_refills, o_pte, o_super); end
    n_checks++; if (o_lat !== 13) begin n_errors++; $display("FAIL bp_latency got %0d want 13", o_lat); end
  endtask

  task automatic test_flush();
    int pulses;
    int busy_ready;
    pulses = 0; busy_ready = 0;
    @(negedge clk);
    bus.satp_ppn_i = 22'h00080; bus.req_vaddr_i = VA; bus.req_asid_i = 9'd3;
    bus.req_valid_i = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      bus.req_valid_i = 1'b0; bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0; bus.flush_i = 1'b0;
      if (bus.refill_valid_o || bus.page_fault_o) pulses++;
      case (cyc)
        1: bus.mem_req_ready_i = 1'b1;
        2: begin bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 32'h0002_0401; end
        3: begin
          n_checks++; if (bus.mem_req_valid_o !== 1'b1 || bus.mem_req_addr_o !== 34'h0_0008_1004) begin n_errors++; $display("FAIL flush_l0_req got v=%b addr=%h want 1/000081004", bus.mem_req_valid_o, bus.mem_req_addr_o); end
          bus.mem_req_ready_i = 1'b1;
        end
        4: bus.flush_i = 1'b1;
        5, 6: if (bus.req_ready_o) busy_ready++;
        7: begin
          if (bus.req_ready_o) busy_ready++;
          bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 32'h0004_8C4B;
        end
        8: begin
          n_checks++; if (bus.req_ready_o !== 1'b1) begin n_errors++; $display("FAIL flush_ready_after_rsp got %b want 1", bus.req_ready_o); end
        end
        default: ;
      endcase
    end
    n_checks++; if (busy_ready !== 0) begin n_errors++; $display("FAIL flush_drain_ready got %0d cycles want 0", busy_ready); end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL flush_no_pulse got %0d pulses want 0", pulses); end
    n_checks++; if (bus.refill_asid_o !== 9'd5) begin n_errors++; $display("FAIL flush_hold_asid got %0d want 5", bus.refill_asid_o); end
    $display("flush walk aborted, pulses=%0d", pulses);
    run_walk(VA, 9'd7, 22'h00080, 32'h0002_0401, 32'h0004_8C4B, 0);
    n_checks++; if (o_refills !== 1 || o_asid !== 9'd7 || o_pte !== 32'h0004_8C4B || o_lat !== 5) begin n_errors++; $display("FAIL flush_next_walk got n=%0d asid=%0d pte=%h lat=%0d want 1/7/00048c4b/5", o_refills, o_asid, o_pte, o_lat); end
  endtask

  task automatic test_reset_mid_walk();
    @(negedge clk);
    bus.satp_ppn_i = 22'h00080; bus.req_vaddr_i = VA; bus.req_asid_i = 9'd2;
    bus.req_valid_i = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.mem_req_ready_i = 1'b1;
    @(negedge clk);  // now in L1_WAIT
    bus.mem_req_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (bus.req_ready_o !== 1'b1 || bus.mem_req_valid_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_handshake got ready=%b mv=%b want 1/0", bus.req_ready_o, bus.mem_req_valid_o); end
    n_checks++; if (bus.mem_req_addr_o !== 34'h0) begin n_errors++; $display("FAIL rstmid_addr got %h want 0", bus.mem_req_addr_o); end
    n_checks++; if (bus.refill_valid_o !== 1'b0 || bus.page_fault_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_pulses got %b/%b want 0/0", bus.refill_valid_o, bus.page_fault_o); end
    n_checks++; if (bus.refill_pte_o !== 32'h0 || bus.refill_asid_o !== 9'd0 || bus.refill_vpn_o !== 20'h0) begin n_errors++; $display("FAIL rstmid_fields got pte=%h asid=%0d vpn=%h want 0", bus.refill_pte_o, bus.refill_asid_o, bus.refill_vpn_o); end
    @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 1'b1 || bus.refill_valid_o !== 1'b0 || bus.page_fault_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_idle got ready=%b refill=%b fault=%b want 1/0/0", bus.req_ready_o, bus.refill_valid_o, bus.page_fault_o); end
    $display("reset mid-walk done");
  endtask

  initial begin
    test_reset();
    test_walk_4k();
    test_megapage();
    test_faults();
    test_backpressure();
    test_flush();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/itlb_ptw.md
Name: itlb_ptw

Overview:
- Sv32 hardware page-table walker that services ITLB misses.
- On a miss request it issues up to two 32-bit PTE reads to the memory/L1 read port, checks the PTE per Sv32 rules, and either returns a refill (VPN, ASID, PTE, level) for the ITLB to write or signals an instruction page fault.
- Sits between the ITLB miss path and the fetch-side memory read port. One walk is in flight at a time.

Parameters:
- VADDR_WD, 32, virtual address width (Sv32)
- PADDR_WD, 34, physical address width
- ASID_WD, 9, address-space ID width
- PPN_WD, 22, physical page number width (satp.PPN, PTE.PPN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  sfence.vma/satp write; abort current walk, no refill
- satp_ppn_i  in  PPN_WD  root page-table PPN
- req_valid_i  in  1  ITLB miss request valid
- req_ready_o  out  1  walker can accept a request
- req_vaddr_i  in  VADDR_WD  missing virtual address
- req_asid_i  in  ASID_WD  ASID of request
- mem_req_valid_o  out  1  PTE read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  PADDR_WD  PTE physical address (word aligned)
- mem_rsp_valid_i  in  1  PTE read data valid (exactly one per accepted request)
- mem_rsp_data_i  in  32  PTE data
- refill_valid_o  out  1  one-cycle pulse: refill fields valid
- refill_vpn_o  out  20  {vpn1,vpn0} of walked address
- refill_asid_o  out  ASID_WD  latched ASID
- refill_pte_o  out  32  leaf PTE
- refill_super_o  out  1  1 = 4 MiB megapage (level-1 leaf)
- page_fault_o  out  1  one-cycle pulse: instruction page fault for latched vaddr

Behaviour:
- Reset: state IDLE; req_ready_o=1; mem_req_valid_o, refill_valid_o, page_fault_o=0; mem_req_addr_o, refill_* = 0.
- FSM: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, FAULT, DRAIN.
- IDLE: req_ready_o=1 only here. On req_valid_i, latch vaddr, ASID and satp_ppn_i; go to L1_REQ.
- L1_REQ: mem_req_valid_o=1, addr = {satp_ppn,12'b0} + {vpn1,2'b00}. Address and valid are held stable until mem_req_ready_i; then go to L1_WAIT.
- L1_WAIT: on mem_rsp_valid_i, capture the PTE and evaluate:
  - Fault if V=0, or (R=0 & W=1).
  - Leaf is R|X. For a leaf, fault if X=0, A=0, or PPN[9:0]!=0 (misaligned superpage). Otherwise set super=1 and go to DONE.
  - Non-leaf goes to L0_REQ with addr = {pte.PPN,12'b0} + {vpn0,2'b00}, truncated to PADDR_WD.
- L0_REQ and L0_WAIT: same request/response handshake as level 1. On the response:
  - Non-leaf, V=0, (R=0 & W=1), X=0 or A=0 goes to FAULT.
  - Otherwise super=0 and go to DONE.
- DONE: refill_valid_o=1 for exactly one cycle, then IDLE.
- FAULT: page_fault_o=1 for exactly one cycle, then IDLE. No refill is issued.
- Latency with memory ready and 1-cycle response, accept to refill pulse: 3 cycles (megapage), 5 cycles (4 KiB page).
- flush_i:
  - In IDLE/DONE/FAULT: no effect on the pulse.
  - In *_REQ before handshake: drop the request and go to IDLE next cycle. If mem_req_ready_i is asserted in the same cycle as flush_i, the request counts as accepted, so go to DRAIN.
  - In *_WAIT: go to DRAIN. DRAIN waits for the outstanding mem_rsp_valid_i, discards it, then goes to IDLE.
  - No refill_valid_o or page_fault_o is issued for an aborted walk.
  - A flush in the same cycle as the response in *_WAIT discards that response and returns to IDLE.
- A mem_rsp_valid_i arriving outside *_WAIT/DRAIN is ignored.
- rst_i mid-walk returns to the reset state immediately. The memory side is reset by the same rst_i.
- refill_* fields hold their value after the pulse until the next DONE.

Test Plan:
- 4 KiB walk: satp_ppn=0x00080, vaddr=0x0040_1234, ASID=5, L1 PTE=0x0002_0401, L0 PTE=0x0004_8C4B → L1 addr 0x0_0008_0004, L0 addr 0x0_0008_1004; refill_vpn=0x00401, pte=0x0004_8C4B, super=0, asid=5, 5 cycles.
- Megapage: same vaddr, L1 PTE=0x0010_004B → single read, refill super=1, pte=0x0010_004B, 3 cycles.
- Faults:
  - L1 PTE=0x0010_044B (misaligned) → page_fault_o pulse, no refill.
  - L0 PTE with V=0 → fault.
  - L0 PTE=0x0004_8C43 (X=0) → fault.
  - L0 PTE non-leaf 0x0002_0401 → fault.
- Backpressure: mem_req_ready_i low for 4 cycles → addr/valid held stable; req_ready_o=0 throughout; walk completes correctly.
- Flush in L0_WAIT: response arrives 3 cycles later → response discarded; no refill/fault; req_ready_o=1 the cycle after response. A new request then walks normally.
- Reset during L1_WAIT → next cycle all outputs at reset values, req_ready_o=1.
